// File: rtl/fma_pkg.sv
// Shared constants, S1 payload and rounding helper for the FMA post-normalizer.
package fma_pkg;

  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int BIAS      = 127;
  localparam int SUM_W     = 75;
  localparam int LZC_W     = 7;
  localparam int EXP_W_EXT = 10;
  localparam int EXP_I     = 12;  // internal signed exponent, wide enough for Exp-lz and Exp+1

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG  = 31'h7F80_0000;
  localparam logic [30:0] MAXF_MAG = 31'h7F7F_FFFF;

  typedef struct packed {
    logic [SUM_W-2:0]        norm;      // hidden bit at the MSB (0 when denormal)
    logic                    stk;
    logic signed [EXP_I-1:0] exp;       // clamped biased exponent, >= 1
    logic                    zero;
    logic                    tiny_neg;  // unbounded exponent < 0
    logic                    tiny_eq0;  // unbounded exponent == 0, tininess decided by rounding
    logic                    sign;
    logic                    sub;
    logic [2:0]              rm;
    logic                    special;
    logic [31:0]             spec_res;
    logic [4:0]              spec_flg;
  } s1_t;

  // Reserved modes fall into the default arm and round like RNE.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic r;
    case (rm)
      RM_RTZ:  r = 1'b0;
      RM_RDN:  r = sign & (g | s);
      RM_RUP:  r = !sign & (g | s);
      RM_RMM:  r = g;
      default: r = g & (s | lsb);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fma_lzc.sv
// Combinational leading-zero counter, counted from the MSB.
module fma_lzc #(
  parameter int WIDTH = 75,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             all_zero_o
);

  // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
  always_comb begin
    count_o    = CNT_W'(WIDTH);
    all_zero_o = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        count_o    = CNT_W'(WIDTH - 1 - i);
        all_zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fma_post_normalizer.sv
// FMA back end: S1 normalizes the adder sum, S2 rounds and packs an IEEE-754 result.
module fma_post_normalizer import fma_pkg::*; #(
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_BIAS  = 127,
  parameter int PARM_SUM_W = 75
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [PARM_SUM_W-1:0]         Mant_sum_i,
  input  logic [EXP_W_EXT-1:0]          Exp_aligned_i,
  input  logic                          Sign_i,
  input  logic                          Sub_i,
  input  logic                          Sticky_i,
  input  logic [2:0]                    Rnd_mode_i,
  input  logic                          Special_i,
  input  logic [31:0]                   Special_result_i,
  input  logic [4:0]                    Special_flags_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [4:0]                    Flags_o
);

  localparam int NW = PARM_SUM_W - 1;
  localparam int M  = PARM_MANT + 1;
  localparam int RW = PARM_EXP + PARM_MANT + 1;
  localparam int WW = 2 * PARM_SUM_W - 1;
  localparam logic signed [EXP_I-1:0] ONE  = EXP_I'(1);
  localparam logic signed [EXP_I-1:0] EMAX = EXP_I'(2 * PARM_BIAS + 1);

  // ---------------- handshake ----------------
  logic [2:1] vld_pipe_q, vld_pipe_d;
  logic       s1_adv, s2_adv;

  always_comb begin
    s2_adv        = !vld_pipe_q[2] | ready_i;
    s1_adv        = !vld_pipe_q[1] | s2_adv;
    vld_pipe_d[1] = s1_adv ? valid_i : vld_pipe_q[1];
    vld_pipe_d[2] = s2_adv ? vld_pipe_q[1] : vld_pipe_q[2];
  end

  assign ready_o = s1_adv;
  assign valid_o = vld_pipe_q[2];

  // ---------------- S1: LZC + normalize ----------------
  logic [LZC_W-1:0]        lz;
  logic                    all_zero;
  logic signed [EXP_I-1:0] exp_in, l0, eu, sh, neg;
  logic                    clamp;
  logic [6:0]              rsh;
  logic [NW-1:0]           lshifted;
  logic [WW-1:0]           rshifted;
  s1_t                     s1_d, s1_q;

  fma_lzc #(.WIDTH(PARM_SUM_W)) u_lzc (
    .data_i     (Mant_sum_i),
    .count_o    (lz),
    .all_zero_o (all_zero)
  );

  // sh is the signed left-shift; negative means a right shift (bit74 set or denormal clamp).
  always_comb begin
    exp_in   = {{(EXP_I-EXP_W_EXT){Exp_aligned_i[EXP_W_EXT-1]}}, Exp_aligned_i};
    l0       = $signed({{(EXP_I-LZC_W){1'b0}}, lz}) - ONE;
    eu       = exp_in - l0;
    clamp    = (eu < ONE);
    sh       = clamp ? (exp_in - ONE) : l0;
    neg      = -sh;
    rsh      = (|neg[EXP_I-1:7]) ? 7'h7F : neg[6:0];
    lshifted = NW'(Mant_sum_i << sh[6:0]);
    rshifted = WW'({Mant_sum_i, {PARM_SUM_W{1'b0}}} >> rsh);

    s1_d          = '0;
    s1_d.exp      = clamp ? ONE : eu;
    s1_d.zero     = all_zero;
    s1_d.tiny_neg = eu[EXP_I-1];
    s1_d.tiny_eq0 = (eu == '0);
    s1_d.sign     = Sign_i;
    s1_d.sub      = Sub_i;
    s1_d.rm       = Rnd_mode_i;
    s1_d.special  = Special_i;
    s1_d.spec_res = Special_result_i;
    s1_d.spec_flg = Special_flags_i;
    if (sh[EXP_I-1]) begin
      s1_d.norm = rshifted[WW-1:PARM_SUM_W];
      s1_d.stk  = Sticky_i | (|rshifted[PARM_SUM_W-1:0]);
    end else begin
      s1_d.norm = lshifted;
      s1_d.stk  = Sticky_i;
    end
  end

  // ---------------- S2: round + pack ----------------
  logic [M-1:0]            m24, mant, m_u;
  logic [M:0]              sum;
  logic                    g, st, inc, carry, g_u, s_u, inc_u, carry_u;
  logic                    nx, tiny, ovf, max_sel, zsign;
  logic signed [EXP_I-1:0] e_r;
  logic [RW-1:0]           res_new, res_d, res_q;
  logic [4:0]              flg_new, flg_d, flg_q;

  always_comb begin
    m24   = s1_q.norm[NW-1 -: M];
    g     = s1_q.norm[NW-1-M];
    st    = (|s1_q.norm[NW-2-M:0]) | s1_q.stk;
    inc   = round_inc(s1_q.rm, s1_q.sign, m24[0], g, st);
    sum   = {1'b0, m24} + {{M{1'b0}}, inc};
    carry = sum[M];
    mant  = carry ? sum[M:1] : sum[M-1:0];
    e_r   = carry ? (s1_q.exp + ONE) : s1_q.exp;
    ovf   = (e_r >= EMAX);
    nx    = g | st;

    // When the unbounded exponent is 0 the stored value is the unbounded one shifted right
    // by one, so its window is one bit lower; a carry there lifts the result out of tiny.
    m_u     = s1_q.norm[NW-2 -: M];
    g_u     = s1_q.norm[NW-2-M];
    s_u     = (|s1_q.norm[NW-3-M:0]) | s1_q.stk;
    inc_u   = round_inc(s1_q.rm, s1_q.sign, m_u[0], g_u, s_u);
    carry_u = (&m_u) & inc_u;
    tiny    = s1_q.tiny_neg | (s1_q.tiny_eq0 & !carry_u);

    max_sel = (s1_q.rm == RM_RTZ) | ((s1_q.rm == RM_RDN) & !s1_q.sign) |
              ((s1_q.rm == RM_RUP) & s1_q.sign);
    zsign   = s1_q.sub ? (s1_q.rm == RM_RDN) : s1_q.sign;

    res_new         = {s1_q.sign, (mant[M-1] ? e_r[PARM_EXP-1:0] : {PARM_EXP{1'b0}}), mant[M-2:0]};
    flg_new         = '0;
    flg_new[FLG_UF] = nx & tiny;
    flg_new[FLG_NX] = nx;
    if (s1_q.special) begin
      res_new = s1_q.spec_res;
      flg_new = s1_q.spec_flg;
    end else if (s1_q.zero) begin
      res_new = {zsign, {(RW-1){1'b0}}};
      flg_new = '0;
    end else if (ovf) begin
      res_new         = {s1_q.sign, (max_sel ? MAXF_MAG : INF_MAG)};
      flg_new         = '0;
      flg_new[FLG_OF] = 1'b1;
      flg_new[FLG_NX] = 1'b1;
    end

    res_d = res_q;
    flg_d = flg_q;
    if (s2_adv & vld_pipe_q[1]) begin
      res_d = res_new;
      flg_d = flg_new;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

  // Payload is qualified by vld_pipe_q[1], so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (valid_i & s1_adv) s1_q <= s1_d;
  end

  assign Result_o = res_q;
  assign Flags_o  = flg_q;

endmodule

// File: tb/tb_fma_post_normalizer.sv
// Directed bench for fma_post_normalizer: normalize, round, overflow, zero, denormal, handshake.
module tb_fma_post_normalizer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [74:0] Mant_sum_i;
  logic [9:0]  Exp_aligned_i;
  logic        Sign_i, Sub_i, Sticky_i;
  logic [2:0]  Rnd_mode_i;
  logic        Special_i;
  logic [31:0] Special_result_i;
  logic [4:0]  Special_flags_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] Result_o;
  logic [4:0]  Flags_o;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [74:0] ONE73 = 75'd1 << 73;
  localparam logic [74:0] ONE74 = 75'd1 << 74;
  localparam logic [74:0] TIE   = (75'd1 << 73) | (75'd1 << 49);
  localparam logic [74:0] ONES  = ((75'd1 << 25) - 75'd1) << 49;

  always #5 clk_i = ~clk_i;

  fma_post_normalizer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .Mant_sum_i       (Mant_sum_i),
    .Exp_aligned_i    (Exp_aligned_i),
    .Sign_i           (Sign_i),
    .Sub_i            (Sub_i),
    .Sticky_i         (Sticky_i),
    .Rnd_mode_i       (Rnd_mode_i),
    .Special_i        (Special_i),
    .Special_result_i (Special_result_i),
    .Special_flags_i  (Special_flags_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .Result_o         (Result_o),
    .Flags_o          (Flags_o)
  );

  task automatic set_in(input logic [74:0] m, input logic [9:0] e, input logic sg,
                        input logic sb, input logic stk, input logic [2:0] rm);
    Mant_sum_i = m; Exp_aligned_i = e; Sign_i = sg; Sub_i = sb; Sticky_i = stk;
    Rnd_mode_i = rm; Special_i = 1'b0; Special_result_i = '0; Special_flags_i = '0;
  endtask

  // Sends one operand into an idle pipe and returns the result and latency (-1 on timeout).
  task automatic do_op(input logic [74:0] m, input logic [9:0] e, input logic sg,
                       input logic sb, input logic stk, input logic [2:0] rm,
                       output logic [31:0] res, output logic [4:0] flg, output int lat);
    @(negedge clk_i);
    ready_i = 1'b1;
    set_in(m, e, sg, sb, stk, rm);
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    res = Result_o;
    flg = Flags_o;
    if (!valid_o) lat = -1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    set_in('0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (3) @(negedge clk_i);
    n_run++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_run++; if (Result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", Result_o); end
    n_run++; if (Flags_o !== 5'h0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", Flags_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_run++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [4:0] f; int lat;
    do_op(ONE73, 10'd127, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h3F80_0000) begin n_fail++; $display("FAIL basic_one: got %h want 3f800000", r); end
    n_run++; if (f !== 5'b00000) begin n_fail++; $display("FAIL basic_flags: got %b want 00000", f); end
    n_run++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic [4:0] f; int lat;
    do_op(ONE74, 10'd127, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL bit74_shift: got %h want 40000000", r); end
    do_op(ONE74, 10'd254, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h7F80_0000) begin n_fail++; $display("FAIL ovf_rne: got %h want 7f800000", r); end
    n_run++; if (f !== 5'b00101) begin n_fail++; $display("FAIL ovf_rne_flags: got %b want 00101", f); end
    do_op(ONE74, 10'd254, 1'b0, 1'b0, 1'b0, 3'b001, r, f, lat);
    n_run++; if (r !== 32'h7F7F_FFFF) begin n_fail++; $display("FAIL ovf_rtz: got %h want 7f7fffff", r); end
    n_run++; if (f !== 5'b00101) begin n_fail++; $display("FAIL ovf_rtz_flags: got %b want 00101", f); end
    do_op(ONE74, 10'd254, 1'b1, 1'b0, 1'b0, 3'b011, r, f, lat);
    n_run++; if (r !== 32'hFF7F_FFFF) begin n_fail++; $display("FAIL ovf_rup_neg: got %h want ff7fffff", r); end
    do_op(ONE74, 10'd254, 1'b1, 1'b0, 1'b0, 3'b010, r, f, lat);
    n_run++; if (r !== 32'hFF80_0000) begin n_fail++; $display("FAIL ovf_rdn_neg: got %h want ff800000", r); end
  endtask

  task automatic test_round();
    logic [31:0] r; logic [4:0] f; int lat;
    do_op(TIE, 10'd127, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h3F80_0000) begin n_fail++; $display("FAIL tie_rne: got %h want 3f800000", r); end
    n_run++; if (f !== 5'b00001) begin n_fail++; $display("FAIL tie_rne_flags: got %b want 00001", f); end
    do_op(TIE, 10'd127, 1'b0, 1'b0, 1'b0, 3'b011, r, f, lat);
    n_run++; if (r !== 32'h3F80_0001) begin n_fail++; $display("FAIL tie_rup: got %h want 3f800001", r); end
    do_op(TIE, 10'd127, 1'b0, 1'b0, 1'b0, 3'b100, r, f, lat);
    n_run++; if (r !== 32'h3F80_0001) begin n_fail++; $display("FAIL tie_rmm: got %h want 3f800001", r); end
    do_op(TIE, 10'd127, 1'b1, 1'b0, 1'b0, 3'b010, r, f, lat);
    n_run++; if (r !== 32'hBF80_0001) begin n_fail++; $display("FAIL tie_rdn_neg: got %h want bf800001", r); end
    do_op(TIE, 10'd127, 1'b0, 1'b0, 1'b0, 3'b111, r, f, lat);
    n_run++; if (r !== 32'h3F80_0000) begin n_fail++; $display("FAIL tie_reserved_rm: got %h want 3f800000", r); end
    do_op(ONES, 10'd127, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL carry_out: got %h want 40000000", r); end
    n_run++; if (f !== 5'b00001) begin n_fail++; $display("FAIL carry_out_flags: got %b want 00001", f); end
  endtask

  task automatic test_zero();
    logic [31:0] r; logic [4:0] f; int lat;
    do_op('0, 10'd127, 1'b0, 1'b1, 1'b0, 3'b010, r, f, lat);
    n_run++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL zero_rdn: got %h want 80000000", r); end
    n_run++; if (f !== 5'b00000) begin n_fail++; $display("FAIL zero_rdn_flags: got %b want 00000", f); end
    do_op('0, 10'd127, 1'b1, 1'b1, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h0000_0000) begin n_fail++; $display("FAIL zero_rne: got %h want 00000000", r); end
  endtask

  task automatic test_denormal();
    logic [31:0] r; logic [4:0] f; int lat;
    do_op(ONE73, 10'h3FB, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h0002_0000) begin n_fail++; $display("FAIL denorm_exact: got %h want 00020000", r); end
    n_run++; if (f !== 5'b00000) begin n_fail++; $display("FAIL denorm_exact_flags: got %b want 00000", f); end
    do_op(ONE73 | 75'd1, 10'h3FB, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h0002_0000) begin n_fail++; $display("FAIL denorm_sticky: got %h want 00020000", r); end
    n_run++; if (f !== 5'b00011) begin n_fail++; $display("FAIL denorm_sticky_flags: got %b want 00011", f); end
    do_op(ONES, 10'd0, 1'b0, 1'b0, 1'b0, 3'b000, r, f, lat);
    n_run++; if (r !== 32'h0080_0000) begin n_fail++; $display("FAIL denorm_to_norm: got %h want 00800000", r); end
    n_run++; if (f !== 5'b00001) begin n_fail++; $display("FAIL denorm_to_norm_flags: got %b want 00001", f); end
    do_op(ONES, 10'd0, 1'b0, 1'b0, 1'b0, 3'b001, r, f, lat);
    n_run++; if (r !== 32'h007F_FFFF) begin n_fail++; $display("FAIL denorm_rtz: got %h want 007fffff", r); end
    n_run++; if (f !== 5'b00011) begin n_fail++; $display("FAIL denorm_rtz_flags: got %b want 00011", f); end
  endtask

  task automatic test_special();
    int lat;
    @(negedge clk_i);
    ready_i = 1'b1;
    set_in(ONE73, 10'd127, 1'b0, 1'b0, 1'b0, 3'b000);
    Special_i = 1'b1; Special_result_i = 32'h7FC0_0000; Special_flags_i = 5'b10000;
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; Special_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin @(negedge clk_i); lat++; end
    n_run++; if (Result_o !== 32'h7FC0_0000 || lat !== 2) begin
      n_fail++; $display("FAIL special_result: got %h lat %0d want 7fc00000 lat 2", Result_o, lat);
    end
    n_run++; if (Flags_o !== 5'b10000) begin n_fail++; $display("FAIL special_flags: got %b want 10000", Flags_o); end
  endtask

  task automatic test_back_to_back();
    logic [74:0] vm [3];
    logic [2:0]  vr [3];
    logic [31:0] er [3];
    logic [4:0]  ef [3];
    int in_idx = 0, out_idx = 0, cyc = 0;
    vm[0] = ONE73; vr[0] = 3'b000; er[0] = 32'h3F80_0000; ef[0] = 5'b00000;
    vm[1] = ONE74; vr[1] = 3'b000; er[1] = 32'h4000_0000; ef[1] = 5'b00000;
    vm[2] = TIE;   vr[2] = 3'b011; er[2] = 32'h3F80_0001; ef[2] = 5'b00001;
    @(negedge clk_i);
    while (out_idx < 3 && cyc < 30) begin
      ready_i = (cyc >= 4);
      valid_i = (in_idx < 3);
      if (in_idx < 3) set_in(vm[in_idx], 10'd127, 1'b0, 1'b0, 1'b0, vr[in_idx]);
      #1;
      if (cyc == 2) begin
        n_run++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b want 0", ready_o); end
      end
      if (cyc == 3) begin
        n_run++; if (valid_o !== 1'b1 || Result_o !== er[0]) begin
          n_fail++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", valid_o, Result_o, er[0]);
        end
      end
      if (valid_o && ready_i) begin
        n_run++; if (Result_o !== er[out_idx] || Flags_o !== ef[out_idx]) begin
          n_fail++; $display("FAIL bp_order_%0d: got %h/%b want %h/%b", out_idx, Result_o, Flags_o, er[out_idx], ef[out_idx]);
        end
        out_idx++;
      end
      if (valid_i && ready_o) in_idx++;
      @(negedge clk_i);
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    n_run++; if (out_idx !== 3) begin n_fail++; $display("FAIL bp_timeout: got %0d results want 3", out_idx); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk_i);
    ready_i = 1'b0;
    set_in(ONE73, 10'd127, 1'b0, 1'b0, 1'b0, 3'b000);
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    n_run++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %b want 1", valid_o); end
    rst_ni = 1'b0;
    #1;
    n_run++; if (valid_o !== 1'b0 || Result_o !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_async: got v=%b %h want v=0 00000000", valid_o, Result_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1; ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_run++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got %b want 0", valid_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_round();
    test_zero();
    test_denormal();
    test_special();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
